jpeg_dequantizer: RTL and testbench

Inverse of the encoder's quantizer/divider pipeline, on the decode side. It multiplies each incoming quantized DCT coefficient, delivered in zig-zag order, by the matching entry of a runtime-loadable 64-entry quantization table. Output is the reconstructed coefficient, sent through a fixed-latency valid pipeline to the IDCT. It is the decoder-side counterpart of the encoder's qnr divider stage and uses the same clk/ena/valid-pipeline style.

---
 rtl/jpeg_dequantizer_if.sv | 30 +++
 rtl/jpeg_dequantizer.sv | 95 +++++++++
 tb/tb_jpeg_dequantizer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/jpeg_dequantizer_if.sv
// Coefficient stream, quant-table load port and dequantized output bundle.
// The master side feeds coefficients and table writes; the slave side is the dequantizer.
interface jpeg_dequantizer_if #(
  parameter int DW = 12,
  parameter int QW = 8,
  parameter int OW = 16
);
  logic                 ena;
  logic                 qnt_we;
  logic [5:0]           qnt_addr;
  logic [QW-1:0]        qnt_val;
  logic                 dstrb;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 dout_valid;
  logic signed [OW-1:0] dout;
  logic                 douz;
  logic [5:0]           dout_idx;
  logic                 dout_sob;

  modport master (
    output ena, qnt_we, qnt_addr, qnt_val, dstrb, din_valid, din,
    input  dout_valid, dout, douz, dout_idx, dout_sob
  );

  modport slave (
    input  ena, qnt_we, qnt_addr, qnt_val, dstrb, din_valid, din,
    output dout_valid, dout, douz, dout_idx, dout_sob
  );
endinterface

// File: rtl/jpeg_dequantizer.sv
// Multiplies zig-zag ordered coefficients by a loadable 64-entry quant table, saturating to OW bits.
// Latency 3 enabled cycles, one coefficient per enabled cycle; ena stalls every stage.
module jpeg_dequantizer #(
  parameter int DW = 12,
  parameter int QW = 8,
  parameter int OW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  jpeg_dequantizer_if.slave    bus
);
  localparam int PW = DW + QW + 1;

  logic [QW-1:0]        tbl_q [64];
  logic [5:0]           cnt_q, cnt_d, idx_d;

  logic [2:0]           spipe_q;
  logic signed [DW-1:0] din1_q;
  logic [5:0]           idx1_q, idx2_q, idx3_q;
  logic                 sob1_q, sob2_q, sob3_q;
  logic [QW-1:0]        q1_q;
  logic signed [PW-1:0] p2_q, p_d;
  logic signed [OW-1:0] dout_q, sat_d;
  logic                 douz_q;
  logic [PW-OW:0]       hi;

  // Table writes ignore ena; a same-cycle read sees the pre-write entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) tbl_q[i] <= QW'(1);
    end else if (bus.qnt_we) begin
      tbl_q[bus.qnt_addr] <= bus.qnt_val;
    end
  end

  always_comb begin
    idx_d = (bus.din_valid && bus.dstrb) ? 6'd0 : cnt_q;
    cnt_d = cnt_q;
    if (bus.ena && bus.din_valid) cnt_d = idx_d + 6'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  always_comb begin
    p_d = $signed({{(QW+1){din1_q[DW-1]}}, din1_q}) * $signed({{DW{1'b0}}, 1'b0, q1_q});
  end

  // Product fits in OW bits only when its top PW-OW+1 bits are all sign copies.
  always_comb begin
    hi    = p2_q[PW-1:OW-1];
    sat_d = p2_q[OW-1:0];
    if (!((&hi) || (~|hi))) begin
      sat_d = p2_q[PW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spipe_q <= '0;
      din1_q  <= '0;
      idx1_q  <= '0;
      sob1_q  <= 1'b0;
      q1_q    <= '0;
      p2_q    <= '0;
      idx2_q  <= '0;
      sob2_q  <= 1'b0;
      dout_q  <= '0;
      douz_q  <= 1'b0;
      idx3_q  <= '0;
      sob3_q  <= 1'b0;
    end else if (bus.ena) begin
      spipe_q <= {spipe_q[1:0], bus.din_valid};
      din1_q  <= bus.din;
      idx1_q  <= idx_d;
      sob1_q  <= (idx_d == 6'd0);
      q1_q    <= tbl_q[idx_d];
      p2_q    <= p_d;
      idx2_q  <= idx1_q;
      sob2_q  <= sob1_q;
      dout_q  <= sat_d;
      douz_q  <= (sat_d == '0);
      idx3_q  <= idx2_q;
      sob3_q  <= sob2_q;
    end
  end

  assign bus.dout_valid = spipe_q[2];
  assign bus.dout       = dout_q;
  assign bus.douz       = douz_q;
  assign bus.dout_idx   = idx3_q;
  assign bus.dout_sob   = sob3_q;
endmodule

// File: tb/tb_jpeg_dequantizer.sv
// Randomized and directed stimulus for jpeg_dequantizer, scored against a plain-arithmetic model.
module tb_jpeg_dequantizer;
  localparam int DW = 12;
  localparam int QW = 8;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jpeg_dequantizer_if #(.DW(DW), .QW(QW), .OW(OW)) bus ();

  jpeg_dequantizer #(.DW(DW), .QW(QW), .OW(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int val;
    int idx;
    int sob;
    int z;
    int stamp;
  } exp_t;

  exp_t sb[$];
  int   tbl[64];
  int   mcnt;
  int   ecnt;
  bit   cap;
  int   checks;
  int   errors;
  int   last_v;
  exp_t last_e;
  exp_t cur;
  int   exp_v;

  function automatic int sat(int p);
    if (p > 32767)  return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Count enabled edges so latency is measured in enabled cycles only.
  always @(posedge clk) begin
    cap = rst && bus.ena;
    if (cap) ecnt++;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (cap) begin
        exp_v = (sb.size() > 0 && (ecnt - sb[0].stamp) == 3) ? 1 : 0;
        chk("dout_valid", int'(bus.dout_valid), exp_v);
        if (exp_v != 0) begin
          cur = sb.pop_front();
          if (bus.dout_valid) begin
            chk("dout", int'(bus.dout), cur.val);
            chk("dout_idx", int'(bus.dout_idx), cur.idx);
            chk("dout_sob", int'(bus.dout_sob), cur.sob);
            chk("douz", int'(bus.douz), cur.z);
          end
          last_e = cur;
        end
        last_v = exp_v;
      end else begin
        chk("hold_valid", int'(bus.dout_valid), last_v);
        if (last_v != 0 && bus.dout_valid) chk("hold_dout", int'(bus.dout), last_e.val);
      end
    end
  end

  task automatic cyc(bit e, bit v, bit s, int d, bit we, int a, int qv);
    exp_t x;
    int   idx;
    @(negedge clk);
    bus.ena       = e;
    bus.din_valid = v;
    bus.dstrb     = s;
    bus.din       = DW'(d);
    bus.qnt_we    = we;
    bus.qnt_addr  = 6'(a);
    bus.qnt_val   = QW'(qv);
    if (e && v) begin
      idx     = s ? 0 : mcnt;
      x.val   = sat(d * tbl[idx]);
      x.idx   = idx;
      x.sob   = (idx == 0) ? 1 : 0;
      x.z     = (x.val == 0) ? 1 : 0;
      x.stamp = ecnt;
      sb.push_back(x);
      mcnt = (idx + 1) % 64;
    end
    if (we) tbl[a] = qv;
  endtask

  task automatic smp(int d, bit s);
    cyc(1'b1, 1'b1, s, d, 1'b0, 0, 0);
  endtask

  task automatic wr(int a, int qv);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, a, qv);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  function automatic int rnd_din();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    bus.din_valid = 1'b0;
    bus.qnt_we    = 1'b0;
    bus.dstrb     = 1'b0;
    #1;
    chk("rst_dout_valid", int'(bus.dout_valid), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_douz", int'(bus.douz), 0);
    chk("rst_dout_idx", int'(bus.dout_idx), 0);
    chk("rst_dout_sob", int'(bus.dout_sob), 0);
    sb.delete();
    mcnt   = 0;
    last_v = 0;
    for (int i = 0; i < 64; i++) tbl[i] = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    bus.ena = 1'b1; bus.din_valid = 1'b0; bus.dstrb = 1'b0; bus.din = '0;
    bus.qnt_we = 1'b0; bus.qnt_addr = '0; bus.qnt_val = '0;
    checks = 0; errors = 0; ecnt = 0; mcnt = 0; last_v = 0;
    for (int i = 0; i < 64; i++) tbl[i] = 1;

    do_reset();

    // Ramp through a full block with the default unity table.
    for (int k = 0; k < 64; k++) smp(k - 32, k == 0);

    // Exact product, positive clamp, negative clamp.
    wr(5, 200);
    wr(6, 255);
    for (int k = 0; k < 7; k++) smp((k == 5) ? -100 : (k == 6) ? 2047 : rnd_din(), k == 0);
    for (int k = 0; k < 7; k++) smp((k == 6) ? -2048 : rnd_din(), k == 0);

    // Table write colliding with a read of the same entry.
    wr(3, 4);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cyc(1'b1, 1'b1, 1'b0, 10, 1'b1, 3, 9);
      else        smp(rnd_din(), k == 0);
    end
    for (int k = 0; k < 4; k++) smp((k == 3) ? 10 : rnd_din(), k == 0);

    // Stall pattern 1,0,0,1 with din_valid held high.
    for (int i = 0; i < 12; i++)
      cyc(!(i % 4 == 1 || i % 4 == 2), 1'b1, i == 0, rnd_din(), 1'b0, 0, 0);

    // dstrb mid-block restarts the index; then a long run that wraps.
    for (int k = 0; k < 20; k++) smp(rnd_din(), k == 0);
    smp(rnd_din(), 1'b1);
    smp(rnd_din(), 1'b0);
    for (int k = 0; k < 70; k++) smp(rnd_din(), 1'b0);

    // Random mix of stalls, bubbles, strobes and table loads (including zero entries).
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          rnd_din(), $urandom_range(0, 7) == 0, int'($urandom_range(0, 63)),
          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));

    // Reset with two samples in flight.
    idle(6);
    smp(5, 1'b0);
    smp(-7, 1'b0);
    do_reset();
    smp(123, 1'b0);
    smp(-5, 1'b0);
    idle(6);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
